// File: rtl/instr_fetch_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
// The fetch stage drives the request (master); memory answers (slave).
interface instr_fetch_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// RiSC-16 instruction fetch: one outstanding imem request, one-entry output
// buffer toward decode, PC advance pulse, and redirect flush with stale-ack drop.
module instr_fetch #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_adv,
    input  logic              redirect,
    instr_fetch_if.master     imem,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] req_addr;
    logic              can_issue;
    logic              load;
    logic              consume;

    // A new fetch may start only when the buffer will be free by the time the
    // response lands, so no prefetch beyond the single entry ever happens.
    assign can_issue = !redirect && (!instr_valid || instr_ready);
    assign load      = (state == FETCH) && imem.imem_ack && !redirect;
    assign consume   = instr_valid && instr_ready;

    // The PC advances exactly when a wanted response is captured.
    assign pc_adv = load;

    assign imem.imem_req  = (state != IDLE);
    assign imem.imem_addr = req_addr;

    // Next-state decode; a redirect while a request is open turns it into a drop.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (can_issue) state_nxt = FETCH;
            FETCH: begin
                if (imem.imem_ack)  state_nxt = IDLE;
                else if (redirect)  state_nxt = DROP;
            end
            DROP:    if (imem.imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Request address is captured only on entry to FETCH, so it is frozen
    // for the whole life of the request (including a DROP tail).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       req_addr <= '0;
        else if (state == IDLE && can_issue) req_addr <= pc_addr;
    end

    // Output buffer valid: redirect flushes, load fills, consume empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        instr_valid <= 1'b0;
        else if (redirect) instr_valid <= 1'b0;
        else if (load)     instr_valid <= 1'b1;
        else if (consume)  instr_valid <= 1'b0;
    end

    // Output buffer payload, written only by a wanted response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= '0;
            instr_pc <= '0;
        end else if (load) begin
            instr    <= imem.imem_rdata;
            instr_pc <= req_addr;
        end
    end
endmodule
